mult_share_arbiter: RTL and testbench

//  Shares one sequential multiplier (start/ready handshake) among NUM_REQ requesters.

---
 rtl/mult_share_arbiter.sv | 137 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier (start/ready handshake)
// among NUM_REQ requesters; returns the product with a one-cycle done pulse.
module mult_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [2*WIDTH-1:0]       result,
    output logic                     err,
    output logic                     busy,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_product
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 err_q, err_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 win_found;
    logic [IdxW-1:0]      win_idx;
    logic [IdxW-1:0]      cand_idx;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand_idx  = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_idx = IdxW'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StIssue;
                    owner_d = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    mul_a_d = op_a[32'(win_idx)*WIDTH +: WIDTH];
                    mul_b_d = op_b[32'(win_idx)*WIDTH +: WIDTH];
                    res_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StIssue: state_d = StArm;
            // The multiplier may still show ready from the previous product here.
            StArm:   state_d = StWait;
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_ready) begin
                    res_d   = mul_product;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                ptr_d   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != StIdle);
    assign mul_start = (state_q == StIssue);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign done      = (state_q == StDone) ? gnt_q : '0;
    assign result    = (state_q == StDone) ? res_q : '0;
    assign err       = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized scoreboard bench for mult_share_arbiter with a behavioural multiplier
// and a round-robin reference model that predicts the whole service order per round.
module tb_mult_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  op_a, op_b;
    logic [N-1:0]    gnt, done;
    logic [PW-1:0]   result;
    logic            err, busy, mul_start;
    logic [W-1:0]    mul_a, mul_b;
    logic            mul_ready;
    logic [PW-1:0]   mul_product;

    mult_share_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ready  (mul_ready),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  oh;
        logic [PW-1:0] res;
        logic          err;
        int            lat;
    } exp_t;

    exp_t         exp_q[$];
    int           lat_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           mptr     = 0;
    int           fixed_lat = 0;
    int           cyc      = 0;
    logic [W-1:0] opa [N][3];
    logic [W-1:0] opb [N][3];
    int           nops [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin : monitor
        int   start_cyc;
        bit   chk_idle;
        exp_t e;
        start_cyc = 0;
        chk_idle  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk_idle = 1'b0;
                continue;
            end
            if (chk_idle) begin
                check("idle_after_done", 64'({busy, gnt}), 64'(0));
                chk_idle = 1'b0;
            end
            check("gnt_onehot", 64'($countones(gnt) <= 1), 64'(1));
            if (mul_start) start_cyc = cyc;
            if (done == '0) begin
                check("quiet_result_err", 64'({result, err}), 64'(0));
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=%b result=%0h, nothing expected", done, result);
            end else begin
                e = exp_q.pop_front();
                check("done_owner", 64'(done), 64'(e.oh));
                check("result", 64'(result), 64'(e.res));
                check("err", 64'(err), 64'(e.err));
                check("latency", 64'(cyc - start_cyc), 64'(e.lat));
                chk_idle = 1'b1;
            end
        end
    end

    // Multiplier model: ready L cycles after start (L == 0 means never).
    initial begin : mult_model
        int           mlat;
        bit           mpend;
        logic [W-1:0] ma, mb;
        mul_ready   = 1'b0;
        mul_product = '0;
        mpend = 1'b0;
        mlat  = 0;
        ma    = '0;
        mb    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mul_ready = 1'b0;
                mpend     = 1'b0;
            end else if (mul_start) begin
                mul_ready   = 1'b0;
                mul_product = $urandom;
                ma = mul_a;
                mb = mul_b;
                mlat = 4;
                if (lat_q.size() > 0) mlat = lat_q.pop_front();
                mpend = (mlat != 0);
            end else if (mpend) begin
                mlat--;
                if (mlat == 0) begin
                    mul_ready   = 1'b1;
                    mul_product = PW'(ma) * PW'(mb);
                    mpend       = 1'b0;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        mptr  = 0;
    endtask

    // Every requester with nops>0 raises req together and holds it until its last done.
    task automatic run_round(input bit hang);
        int           rem [N];
        int           served [N];
        int           ptr, w, total, budget, it, idx, l;
        logic [N-1:0] first_oh;
        exp_t         e;
        for (int k = 0; k < N; k++) begin
            rem[k]    = nops[k];
            served[k] = 0;
        end
        ptr      = mptr;
        total    = 0;
        first_oh = '0;
        while (1) begin
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && rem[(ptr + i) % N] > 0) w = (ptr + i) % N;
            if (w < 0) break;
            idx   = nops[w] - rem[w];
            l     = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 12));
            e.oh  = N'(1 << w);
            e.res = hang ? '0 : PW'(opa[w][idx]) * PW'(opb[w][idx]);
            e.err = hang;
            e.lat = hang ? int'(TO) + 2 : l + 1;
            exp_q.push_back(e);
            lat_q.push_back(hang ? 0 : l);
            if (total == 0) first_oh = e.oh;
            rem[w]--;
            ptr = (w + 1) % N;
            total++;
        end
        mptr = ptr;

        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (nops[k] > 0) begin
                req[k] = 1'b1;
                op_a[k*W +: W] = opa[k][0];
                op_b[k*W +: W] = opb[k][0];
            end
        end
        budget = total * (int'(TO) + 8) + 10;
        it = 0;
        while (req != '0 && it < budget) begin
            @(negedge clk);
            if (it == 0) begin
                check("start_latency", 64'(mul_start), 64'(1));
                check("first_grant", 64'(gnt), 64'(first_oh));
            end
            for (int k = 0; k < N; k++) begin
                if (done[k]) begin
                    served[k]++;
                    if (served[k] >= nops[k]) begin
                        req[k] = 1'b0;
                    end else begin
                        op_a[k*W +: W] = opa[k][served[k]];
                        op_b[k*W +: W] = opb[k][served[k]];
                    end
                end else if (gnt[k]) begin
                    // Owner's operands were sampled at grant; disturb them.
                    op_a[k*W +: W] = W'($urandom);
                    op_b[k*W +: W] = W'($urandom);
                end
            end
            it++;
        end
        if (req != '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL round_timeout: req=%b still pending after %0d cycles", req, budget);
            do_reset(2);
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic set_ops(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            nops[k] = mask[k] ? 1 : 0;
            opa[k][0] = W'($urandom);
            opb[k][0] = W'($urandom);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1;
        req   = '1;
        op_a  = '0;
        op_b  = '0;

        // Reset with all requests high.
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 64'({gnt, done, mul_start, busy, err, result}), 64'(0));
        end
        reset = 1'b0;
        req   = '0;

        // Single request, fixed latency 8.
        set_ops(4'b0001);
        opa[0][0] = 16'd3;
        opb[0][0] = 16'd5;
        fixed_lat = 8;
        run_round(1'b0);
        fixed_lat = 0;

        // Full contention from ptr 0, twice.
        do_reset(1);
        set_ops(4'b1111);
        run_round(1'b0);
        set_ops(4'b1111);
        run_round(1'b0);

        // Serve 2, then 1 and 3 compete: 3 wins first.
        set_ops(4'b0100);
        run_round(1'b0);
        set_ops(4'b1010);
        opa[3][0] = 16'hFFFF;
        opb[3][0] = 16'hFFFF;
        run_round(1'b0);

        // Multiplier never ready: timeout abort, then a normal op.
        set_ops(4'b0001);
        run_round(1'b1);
        set_ops(4'b0010);
        run_round(1'b0);

        // Back-to-back re-requests from two requesters.
        set_ops(4'b0011);
        nops[0] = 3;
        nops[1] = 2;
        for (int j = 1; j < 3; j++) begin
            opa[0][j] = W'($urandom);
            opb[0][j] = W'($urandom);
            opa[1][j] = W'($urandom);
            opb[1][j] = W'($urandom);
        end
        run_round(1'b0);

        // Reset while waiting on the multiplier.
        @(negedge clk);
        req = 4'b0100;
        op_a[2*W +: W] = W'($urandom);
        op_b[2*W +: W] = W'($urandom);
        lat_q.push_back(10);
        repeat (3) @(negedge clk);
        check("wait_busy", 64'({busy, gnt}), 64'({1'b1, 4'b0100}));
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("abort_idle", 64'({busy, gnt, done, err}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        mptr  = 0;
        lat_q.delete();
        set_ops(4'b0100);
        opa[2][0] = 16'd7;
        opb[2][0] = 16'd9;
        run_round(1'b0);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < N; k++) begin
                nops[k] = int'($urandom_range(0, 3));
                for (int j = 0; j < 3; j++) begin
                    opa[k][j] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    opb[k][j] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                end
            end
            if (nops[0] + nops[1] + nops[2] + nops[3] == 0) nops[$urandom_range(0, N - 1)] = 1;
            run_round($urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
